// File: rtl/dca_matrix_mlsu_inst_dispatcher_if.sv
// Control/MLSU bundle of the MLSU instruction dispatcher.
// slave = dispatcher view, master = surrounding MMIOX/MLSU view.
interface dca_matrix_mlsu_inst_dispatcher_if #(
  parameter int NUM_MLSU    = 3,
  parameter int BW_LSU_INST = 64,
  parameter int BW_LOG      = 32
);
  localparam int BW_INST   = 1 + NUM_MLSU + BW_LSU_INST;
  localparam int BW_STATUS = NUM_MLSU + 4;

  logic                            core_enable;
  logic [BW_STATUS-1:0]            core_status;
  logic                            clear_request;
  logic                            clear_finish;
  logic                            inst_fifo_rready;
  logic [BW_INST-1:0]              inst_fifo_rdata;
  logic                            inst_fifo_rrequest;
  logic                            operation_finish;
  logic                            log_fifo_wready;
  logic                            log_fifo_wrequest;
  logic [BW_LOG-1:0]               log_fifo_wdata;
  logic [NUM_MLSU-1:0]             mlsu_sinst_wvalid;
  logic [NUM_MLSU*BW_LSU_INST-1:0] mlsu_sinst_wdata;
  logic [NUM_MLSU-1:0]             mlsu_sinst_wready;
  logic [NUM_MLSU-1:0]             mlsu_sinst_execute_finish;
  logic [NUM_MLSU-1:0]             mlsu_sinst_busy;

  modport slave (
    input  core_enable, clear_request, inst_fifo_rready, inst_fifo_rdata, log_fifo_wready,
           mlsu_sinst_wready, mlsu_sinst_execute_finish, mlsu_sinst_busy,
    output core_status, clear_finish, inst_fifo_rrequest, operation_finish,
           log_fifo_wrequest, log_fifo_wdata, mlsu_sinst_wvalid, mlsu_sinst_wdata
  );

  modport master (
    output core_enable, clear_request, inst_fifo_rready, inst_fifo_rdata, log_fifo_wready,
           mlsu_sinst_wready, mlsu_sinst_execute_finish, mlsu_sinst_busy,
    input  core_status, clear_finish, inst_fifo_rrequest, operation_finish,
           log_fifo_wrequest, log_fifo_wdata, mlsu_sinst_wvalid, mlsu_sinst_wdata
  );
endinterface

// File: rtl/dca_matrix_mlsu_inst_dispatcher.sv
// MMIOX inst FIFO -> NUM_MLSU matrix LSU multicast dispatcher with per-channel
// outstanding tracking, barrier/log sequencing and clear handling.
module dca_matrix_mlsu_inst_dispatcher_chan #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic rstp,
  input  logic req_i,
  input  logic wready_i,
  input  logic finish_i,
  input  logic busy_i,
  output logic wvalid_o,
  output logic accept_o,
  output logic active_o,
  output logic err_o
);
  localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          raised_q, raised_d;
  logic          dec;

  // raised_q keeps a presented inst on the bus until taken, whatever the FSM does
  always_comb begin
    wvalid_o = raised_q | (req_i & (cnt_q < CNT_MAX));
    accept_o = wvalid_o & wready_i;
    err_o    = finish_i & (cnt_q == '0);
    dec      = finish_i & ~err_o;
    active_o = (cnt_q != '0) | busy_i;
    raised_d = wvalid_o & ~wready_i;
    cnt_d    = cnt_q;
    if (accept_o && !dec)      cnt_d = cnt_q + CW'(1);
    else if (!accept_o && dec) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      cnt_q    <= '0;
      raised_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      raised_q <= raised_d;
    end
  end
endmodule

module dca_matrix_mlsu_inst_dispatcher #(
  parameter int NUM_MLSU        = 3,
  parameter int BW_LSU_INST     = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int BW_LOG          = 32
) (
  input  logic                              clk,
  input  logic                              rstp,
  dca_matrix_mlsu_inst_dispatcher_if.slave  ctl_io
);
  localparam int BW_INST = 1 + NUM_MLSU + BW_LSU_INST;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_BARRIER = 3'd2,
    S_LOG     = 3'd3,
    S_CLEAR   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [BW_LSU_INST-1:0] payload_q, payload_d;
  logic [NUM_MLSU-1:0]    pending_q, pending_d;
  logic [BW_LOG-1:0]      seq_q, seq_d;
  logic                   err_q, err_d;
  logic                   clr_blk_q, clr_blk_d;

  logic [NUM_MLSU-1:0] issue_req, wvalid, accept, active, err_v;
  logic                clr_go, pop, log_push, clr_fin;

  assign issue_req = {NUM_MLSU{state_q == S_ISSUE}} & pending_q;

  for (genvar i = 0; i < NUM_MLSU; i++) begin : g_chan
    dca_matrix_mlsu_inst_dispatcher_chan #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_chan (
      .clk      (clk),
      .rstp     (rstp),
      .req_i    (issue_req[i]),
      .wready_i (ctl_io.mlsu_sinst_wready[i]),
      .finish_i (ctl_io.mlsu_sinst_execute_finish[i]),
      .busy_i   (ctl_io.mlsu_sinst_busy[i]),
      .wvalid_o (wvalid[i]),
      .accept_o (accept[i]),
      .active_o (active[i]),
      .err_o    (err_v[i])
    );
  end

  // clr_blk_q masks a request still held after a clear, so a new clear needs a fresh rising level
  assign clr_go = ctl_io.clear_request & ~clr_blk_q & (state_q != S_CLEAR);

  always_comb begin
    state_d   = state_q;
    payload_d = payload_q;
    pending_d = pending_q;
    seq_d     = seq_q;
    err_d     = err_q | (|err_v);
    clr_blk_d = clr_blk_q & ctl_io.clear_request;
    pop       = 1'b0;
    log_push  = 1'b0;
    clr_fin   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        pop = ctl_io.inst_fifo_rready & ctl_io.core_enable & ~ctl_io.clear_request;
        if (pop) begin
          payload_d = ctl_io.inst_fifo_rdata[BW_LSU_INST-1:0];
          if (ctl_io.inst_fifo_rdata[BW_INST-1]) begin
            state_d = S_BARRIER;
          end else begin
            state_d   = S_ISSUE;
            pending_d = ctl_io.inst_fifo_rdata[BW_LSU_INST +: NUM_MLSU];
          end
        end
      end
      S_ISSUE: begin
        pending_d = pending_q & ~accept;
        if (pending_d == '0) state_d = S_IDLE;
      end
      S_BARRIER: begin
        if (active == '0) state_d = S_LOG;
      end
      S_LOG: begin
        log_push = ctl_io.log_fifo_wready & ~clr_go;
        if (log_push) begin
          seq_d   = seq_q + BW_LOG'(1);
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (wvalid == '0 && active == '0) begin
          clr_fin   = 1'b1;
          seq_d     = '0;
          err_d     = 1'b0;
          pending_d = '0;
          clr_blk_d = ctl_io.clear_request;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // not-yet-raised channels are dropped; raised ones stay held inside the channel
    if (clr_go) begin
      state_d   = S_CLEAR;
      pending_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      state_q   <= S_IDLE;
      payload_q <= '0;
      pending_q <= '0;
      seq_q     <= '0;
      err_q     <= 1'b0;
      clr_blk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
      pending_q <= pending_d;
      seq_q     <= seq_d;
      err_q     <= err_d;
      clr_blk_q <= clr_blk_d;
    end
  end

  assign ctl_io.core_status        = {err_q, state_q, active};
  assign ctl_io.clear_finish       = clr_fin;
  assign ctl_io.inst_fifo_rrequest = pop;
  assign ctl_io.operation_finish   = log_push;
  assign ctl_io.log_fifo_wrequest  = log_push;
  assign ctl_io.log_fifo_wdata     = seq_q;
  assign ctl_io.mlsu_sinst_wvalid  = wvalid;
  assign ctl_io.mlsu_sinst_wdata   = {NUM_MLSU{payload_q}};
endmodule

// File: tb/tb_dca_matrix_mlsu_inst_dispatcher.sv
// Bench for the MLSU inst dispatcher: vector table, directed corner sequences,
// and a randomized run scored against a transaction-level model.
module tb_dca_matrix_mlsu_inst_dispatcher;
  localparam int N  = 3;
  localparam int BP = 64;
  localparam int MO = 4;
  localparam int BL = 32;
  localparam int BI = 1 + N + BP;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_ISSUE = 3'd1, ST_BAR = 3'd2,
                         ST_LOG  = 3'd3, ST_CLR   = 3'd4;

  logic clk = 1'b0;
  logic rstp;
  always #5 clk = ~clk;

  dca_matrix_mlsu_inst_dispatcher_if #(.NUM_MLSU(N), .BW_LSU_INST(BP), .BW_LOG(BL)) bus ();

  dca_matrix_mlsu_inst_dispatcher #(
    .NUM_MLSU(N), .BW_LSU_INST(BP), .MAX_OUTSTANDING(MO), .BW_LOG(BL)
  ) u_dut (
    .clk    (clk),
    .rstp   (rstp),
    .ctl_io (bus)
  );

  wire [N-1:0][BP-1:0] lanes;
  assign lanes = bus.mlsu_sinst_wdata;
  wire [2:0] st_f = bus.core_status[N+2:N];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [BI-1:0] mk(input logic b, input logic [N-1:0] m, input logic [BP-1:0] p);
    return {b, m, p};
  endfunction

  function automatic logic [N+3:0] stv(input logic e, input logic [2:0] s, input logic [N-1:0] a);
    return {e, s, a};
  endfunction

  task automatic idle_inputs();
    bus.core_enable               = 1'b1;
    bus.clear_request             = 1'b0;
    bus.inst_fifo_rready          = 1'b0;
    bus.inst_fifo_rdata           = '0;
    bus.log_fifo_wready           = 1'b1;
    bus.mlsu_sinst_wready         = '1;
    bus.mlsu_sinst_execute_finish = '0;
    bus.mlsu_sinst_busy           = '0;
  endtask

  // present one word in IDLE, expect it to be popped this cycle
  task automatic pop(input logic [BI-1:0] w, input string nm);
    bus.inst_fifo_rready = 1'b1;
    bus.inst_fifo_rdata  = w;
    settle();
    chk(nm, bus.inst_fifo_rrequest, 1'b1);
    tick();
    bus.inst_fifo_rready = 1'b0;
    bus.inst_fifo_rdata  = '0;
  endtask

  typedef struct {
    logic [N-1:0]  mask;
    logic [BP-1:0] pl;
    logic [N-1:0]  exp_wv;
    logic [N-1:0]  exp_act;
  } vec_t;
  vec_t vecs[5];

  // randomized-run model state
  logic [BI-1:0] fq[$];
  logic [BP-1:0] expq[N][$];
  int            mcnt[N];
  bit            bar_pend;
  int            seq_m, nbar, cyc;
  bit            done, allz, pop_ok;
  logic [N-1:0]  fin_r, busy_r, wr_r, act_e, prev_wv, prev_wr;
  logic [BP-1:0] prev_data[N];
  logic [BI-1:0] w;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rstp = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    settle();
    chk("reset_status", bus.core_status, '0);
    chk("reset_wvalid", bus.mlsu_sinst_wvalid, '0);
    chk("reset_strobes", {bus.inst_fifo_rrequest, bus.log_fifo_wrequest, bus.operation_finish, bus.clear_finish}, 4'b0);
    chk("reset_data", {bus.log_fifo_wdata, bus.mlsu_sinst_wdata}, '0);
    rstp = 1'b0;
    tick();

    // ---- vector table: single multicast insts from a quiet state
    vecs[0] = '{3'b101, 64'hA5A5_0000_0000_0001, 3'b101, 3'b101};
    vecs[1] = '{3'b111, 64'h0123_4567_89AB_CDEF, 3'b111, 3'b111};
    vecs[2] = '{3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010, 3'b010};
    vecs[3] = '{3'b000, 64'hDEAD_BEEF_0000_0000, 3'b000, 3'b000};
    vecs[4] = '{3'b100, 64'h0000_0000_0000_0000, 3'b100, 3'b100};
    for (int v = 0; v < 5; v++) begin
      pop(mk(1'b0, vecs[v].mask, vecs[v].pl), "vec_pop");
      settle();
      chk("vec_issue_state", st_f, ST_ISSUE);
      chk("vec_wvalid", bus.mlsu_sinst_wvalid, vecs[v].exp_wv);
      for (int c = 0; c < N; c++)
        if (vecs[v].exp_wv[c]) chk("vec_wdata", lanes[c], vecs[v].pl);
      tick();
      settle();
      chk("vec_after", bus.core_status, stv(1'b0, ST_IDLE, vecs[v].exp_act));
      bus.mlsu_sinst_execute_finish = vecs[v].mask;
      tick();
      bus.mlsu_sinst_execute_finish = '0;
      settle();
      chk("vec_drained", bus.core_status, stv(1'b0, ST_IDLE, 3'b000));
    end

    // ---- T2: ch1 back-pressured for five cycles
    pop(mk(1'b0, 3'b111, 64'h1111_2222_3333_4444), "t2_pop");
    bus.mlsu_sinst_wready = 3'b101;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("t2_wvalid", bus.mlsu_sinst_wvalid, (k == 0) ? 3'b111 : 3'b010);
      chk("t2_ch1_data", lanes[1], 64'h1111_2222_3333_4444);
      tick();
    end
    bus.mlsu_sinst_wready = 3'b111;
    settle();
    chk("t2_release", bus.mlsu_sinst_wvalid, 3'b010);
    tick();
    settle();
    chk("t2_done", bus.core_status, stv(1'b0, ST_IDLE, 3'b111));
    bus.mlsu_sinst_execute_finish = 3'b111;
    tick();
    bus.mlsu_sinst_execute_finish = '0;

    // ---- T3: outstanding limit on ch0
    for (int k = 0; k < 4; k++) begin
      pop(mk(1'b0, 3'b001, 64'(k)), "t3_pop");
      tick();
    end
    pop(mk(1'b0, 3'b001, 64'h55), "t3_pop5");
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t3_stalled", {st_f, bus.mlsu_sinst_wvalid}, {ST_ISSUE, 3'b000});
      tick();
    end
    bus.mlsu_sinst_execute_finish = 3'b001;
    settle();
    chk("t3_stall_on_finish", bus.mlsu_sinst_wvalid, 3'b000);
    tick();
    bus.mlsu_sinst_execute_finish = '0;
    settle();
    chk("t3_issued", bus.mlsu_sinst_wvalid, 3'b001);
    chk("t3_wdata", lanes[0], 64'h55);
    tick();
    settle();
    chk("t3_idle", st_f, ST_IDLE);
    bus.mlsu_sinst_execute_finish = 3'b001;
    repeat (4) tick();
    bus.mlsu_sinst_execute_finish = '0;
    settle();
    chk("t3_drained", bus.core_status, stv(1'b0, ST_IDLE, 3'b000));

    // ---- T4: barrier waits for finishes and log space
    pop(mk(1'b0, 3'b001, 64'hA), "t4_popA");
    tick();
    pop(mk(1'b0, 3'b010, 64'hB), "t4_popB");
    tick();
    bus.log_fifo_wready = 1'b0;
    pop(mk(1'b1, 3'b111, 64'hFF), "t4_popbar");
    for (int c = 1; c <= 27; c++) begin
      bus.mlsu_sinst_execute_finish = (c == 10) ? 3'b001 : (c == 20) ? 3'b010 : 3'b000;
      bus.log_fifo_wready = (c >= 25);
      settle();
      chk("t4_state", st_f, (c <= 21) ? ST_BAR : (c <= 25) ? ST_LOG : ST_IDLE);
      chk("t4_opfin", bus.operation_finish, (c == 25));
      chk("t4_logreq", bus.log_fifo_wrequest, (c == 25));
      if (c == 25) chk("t4_logdata", bus.log_fifo_wdata, 32'd0);
      tick();
    end
    bus.mlsu_sinst_execute_finish = '0;
    pop(mk(1'b1, 3'b000, 64'h0), "t4_popbar2");
    settle();
    chk("t4_bar2_state", st_f, ST_BAR);
    tick();
    settle();
    chk("t4_bar2_log", {bus.log_fifo_wrequest, bus.operation_finish, bus.log_fifo_wdata}, {2'b11, 32'd1});
    tick();
    settle();
    chk("t4_bar2_idle", st_f, ST_IDLE);

    // ---- T6: spurious finish, then accept+finish in one cycle
    bus.mlsu_sinst_execute_finish = 3'b100;
    tick();
    bus.mlsu_sinst_execute_finish = '0;
    settle();
    chk("t6_err", bus.core_status, stv(1'b1, ST_IDLE, 3'b000));
    pop(mk(1'b0, 3'b001, 64'hC), "t6_popC");
    tick();
    pop(mk(1'b0, 3'b001, 64'hD), "t6_popD");
    bus.mlsu_sinst_execute_finish = 3'b001;
    settle();
    chk("t6_accept", bus.mlsu_sinst_wvalid, 3'b001);
    tick();
    bus.mlsu_sinst_execute_finish = '0;
    settle();
    chk("t6_cnt_same", bus.core_status, stv(1'b1, ST_IDLE, 3'b001));
    bus.mlsu_sinst_execute_finish = 3'b001;
    tick();
    bus.mlsu_sinst_execute_finish = '0;
    settle();
    chk("t6_cnt_zero", bus.core_status, stv(1'b1, ST_IDLE, 3'b000));

    // ---- T5: clear while ch1 is held
    pop(mk(1'b0, 3'b111, 64'hEEEE), "t5_pop");
    bus.mlsu_sinst_wready = 3'b101;
    settle();
    chk("t5_wv0", bus.mlsu_sinst_wvalid, 3'b111);
    tick();
    bus.clear_request = 1'b1;
    settle();
    chk("t5_wv1", bus.mlsu_sinst_wvalid, 3'b010);
    tick();
    settle();
    chk("t5_clear_state", {st_f, bus.mlsu_sinst_wvalid, bus.clear_finish}, {ST_CLR, 3'b010, 1'b0});
    chk("t5_held_data", lanes[1], 64'hEEEE);
    tick();
    settle();
    chk("t5_held2", bus.mlsu_sinst_wvalid, 3'b010);
    tick();
    bus.mlsu_sinst_wready = 3'b111;
    settle();
    chk("t5_held3", bus.mlsu_sinst_wvalid, 3'b010);
    tick();
    settle();
    chk("t5_wait_cnt", {bus.core_status, bus.clear_finish}, {stv(1'b1, ST_CLR, 3'b111), 1'b0});
    bus.mlsu_sinst_execute_finish = 3'b111;
    tick();
    bus.mlsu_sinst_execute_finish = '0;
    settle();
    chk("t5_clear_finish", bus.clear_finish, 1'b1);
    tick();
    bus.inst_fifo_rready = 1'b1;
    bus.inst_fifo_rdata  = mk(1'b0, 3'b001, 64'hF);
    settle();
    chk("t5_status", bus.core_status, stv(1'b0, ST_IDLE, 3'b000));
    chk("t5_fetch_blocked", bus.inst_fifo_rrequest, 1'b0);
    tick();
    settle();
    chk("t5_no_reenter", {st_f, bus.clear_finish}, {ST_IDLE, 1'b0});
    bus.inst_fifo_rready = 1'b0;
    bus.clear_request    = 1'b0;
    tick();
    pop(mk(1'b1, 3'b000, 64'h0), "t5_popbar");
    tick();
    settle();
    chk("t5_seq_reset", {bus.log_fifo_wrequest, bus.log_fifo_wdata}, {1'b1, 32'd0});
    tick();
    bus.clear_request = 1'b1;
    settle();
    tick();
    bus.clear_request = 1'b0;
    settle();
    chk("clr_edge_finish", {st_f, bus.clear_finish}, {ST_CLR, 1'b1});
    tick();
    settle();
    chk("clr_edge_idle", bus.core_status, stv(1'b0, ST_IDLE, 3'b000));

    // ---- core_enable gating
    bus.core_enable      = 1'b0;
    bus.inst_fifo_rready = 1'b1;
    bus.inst_fifo_rdata  = mk(1'b0, 3'b001, 64'h77);
    settle();
    chk("en_blocked", bus.inst_fifo_rrequest, 1'b0);
    tick();
    settle();
    chk("en_idle", st_f, ST_IDLE);
    bus.core_enable = 1'b1;
    settle();
    chk("en_pop", bus.inst_fifo_rrequest, 1'b1);
    tick();
    bus.inst_fifo_rready = 1'b0;
    tick();
    bus.mlsu_sinst_execute_finish = 3'b001;
    tick();
    bus.mlsu_sinst_execute_finish = '0;

    // ---- randomized run against transaction-level model
    nbar = 0;
    for (int k = 0; k < 120; k++) begin
      w = mk(($urandom_range(7) == 0), N'($urandom), {$urandom, $urandom});
      if (w[BI-1]) nbar++;
      fq.push_back(w);
    end
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    bar_pend = 1'b0;
    seq_m    = 0;
    prev_wv  = '0;
    prev_wr  = '0;
    cyc      = 0;
    done     = 1'b0;
    while (!done && cyc < 20000) begin
      bus.core_enable      = ($urandom_range(7) != 0);
      bus.inst_fifo_rready = (fq.size() > 0) && ($urandom_range(3) != 0);
      bus.inst_fifo_rdata  = (fq.size() > 0) ? fq[0] : '0;
      bus.log_fifo_wready  = $urandom_range(1);
      wr_r = N'($urandom);
      for (int i = 0; i < N; i++) begin
        fin_r[i]  = (mcnt[i] > 0) && ($urandom_range(3) == 0);
        busy_r[i] = ($urandom_range(15) == 0);
      end
      bus.mlsu_sinst_wready         = wr_r;
      bus.mlsu_sinst_execute_finish = fin_r;
      bus.mlsu_sinst_busy           = busy_r;
      settle();

      if (bus.inst_fifo_rrequest) begin
        pop_ok = bus.inst_fifo_rready && bus.core_enable && !bar_pend && (fq.size() > 0);
        for (int i = 0; i < N; i++) if (expq[i].size() != 0) pop_ok = 1'b0;
        chk("rand_pop_legal", pop_ok, 1'b1);
        if (fq.size() > 0) begin
          w = fq.pop_front();
          if (w[BI-1]) bar_pend = 1'b1;
          else for (int i = 0; i < N; i++) if (w[BP+i]) expq[i].push_back(w[BP-1:0]);
        end
      end

      allz = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (mcnt[i] != 0) allz = 1'b0;
        act_e[i] = (mcnt[i] != 0) || busy_r[i];
        if (prev_wv[i] && !prev_wr[i])
          chk("rand_hold", {bus.mlsu_sinst_wvalid[i], lanes[i]}, {1'b1, prev_data[i]});
        if (bus.mlsu_sinst_wvalid[i] && wr_r[i]) begin
          chk("rand_outstanding", (mcnt[i] < MO), 1'b1);
          if (expq[i].size() == 0) chk("rand_accept_expected", 1'b0, 1'b1);
          else chk("rand_accept_data", lanes[i], expq[i].pop_front());
          mcnt[i]++;
        end
        if (fin_r[i]) mcnt[i]--;
        prev_data[i] = lanes[i];
      end
      chk("rand_active", bus.core_status[N-1:0], act_e);

      if (bus.log_fifo_wrequest || bus.operation_finish) begin
        chk("rand_log", {bus.log_fifo_wrequest, bus.operation_finish, bar_pend, allz, bus.log_fifo_wdata},
            {4'b1111, 32'(seq_m)});
        seq_m++;
        bar_pend = 1'b0;
      end

      prev_wv = bus.mlsu_sinst_wvalid;
      prev_wr = wr_r;
      tick();
      cyc++;
      done = (fq.size() == 0) && !bar_pend;
      for (int i = 0; i < N; i++) if (expq[i].size() != 0 || mcnt[i] != 0) done = 1'b0;
    end
    idle_inputs();
    settle();
    chk("rand_drained", done, 1'b1);
    chk("rand_barriers", seq_m, nbar);
    chk("rand_final_status", bus.core_status, stv(1'b0, ST_IDLE, 3'b000));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
